// File: rtl/dmem_arb_pkg.sv
// Shared types and port indices for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_LOAD = 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: grants the single requester, or on a tie the port that did not go last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core and the loader/DMA,
// with bounded locked bursts.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic          r0_lock,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic          r1_lock,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BurstMax = BW'(MAX_BURST);

    arb_state_t    state_q, state_d;
    logic          last_q, last_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]    pick;
    logic [1:0]    gnt;
    logic          xfer_lock;
    logic          rd0, rd1;
    logic          r0_rvalid_q, r1_rvalid_q;
    logic [DW-1:0] r0_rdata_q, r1_rdata_q;

    rr_pick2 u_pick (
        .req  ({r1_req, r0_req}),
        .last (last_q),
        .pick (pick)
    );

    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            unique case (state_q)
                ARB:     gnt = pick;
                LOCK0:   gnt = {1'b0, r0_req};
                LOCK1:   gnt = {r1_req, 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        xfer_lock   = gnt[PORT_LOAD] ? r1_lock : r0_lock;
        if (gnt != 2'b00) begin
            last_d = gnt[PORT_LOAD];
            if (state_q == ARB) begin
                // A burst of one is just a plain transfer, so never enter a lock state.
                if (xfer_lock && MAX_BURST > 1) begin
                    state_d     = gnt[PORT_LOAD] ? LOCK1 : LOCK0;
                    burst_cnt_d = BW'(1);
                end
            end else if (!xfer_lock || (burst_cnt_q + 1'b1) == BurstMax) begin
                state_d     = ARB;
                burst_cnt_d = '0;
            end else begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end
        end
    end

    assign rd0 = gnt[PORT_CORE] & ~r0_we;
    assign rd1 = gnt[PORT_LOAD] & ~r1_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            r0_rvalid_q <= rd0;
            r1_rvalid_q <= rd1;
            if (rd0) r0_rdata_q <= m_rdata;
            if (rd1) r1_rdata_q <= m_rdata;
        end
    end

    assign r0_gnt    = gnt[PORT_CORE];
    assign r1_gnt    = gnt[PORT_LOAD];
    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_rdata  = r0_rdata_q;
    assign r1_rdata  = r1_rdata_q;

    assign m_addr  = gnt[PORT_LOAD] ? r1_addr : r0_addr;
    assign m_wdata = gnt[PORT_LOAD] ? r1_wdata : r0_wdata;
    assign m_we    = (gnt[PORT_CORE] & r0_we) | (gnt[PORT_LOAD] & r1_we);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of ownership, round-robin order and memory contents.
module tb_dmem_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, m_we;
    logic [31:0] r0_rdata, r1_rdata, m_addr, m_wdata, m_rdata;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // dmem-equivalent memory: combinational read, write on posedge
    logic [31:0] mem [256];
    assign m_rdata = mem[m_addr[9:2]];
    always @(posedge clk) if (m_we) mem[m_addr[9:2]] <= m_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;
    exp_t exp0[$];
    exp_t exp1[$];

    int checks = 0;
    int errors = 0;

    // Reference model: owner of a lock (-1 = none), transfers in the burst, last winner
    int          owner, burst, last;
    logic [31:0] shadow [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        burst = 0;
        last  = 1;
        exp0.delete();
        exp1.delete();
    endtask

    task automatic mon(input int p, input logic v, input logic [31:0] d);
        exp_t e;
        bit   have;
        have = (p == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
        if (have) e = (p == 0) ? exp0[0] : exp1[0];
        if (v) begin
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL rvalid%0d: got unexpected read data %h (cycle %0d)", p, d, cyc);
            end else begin
                if (p == 0) void'(exp0.pop_front()); else void'(exp1.pop_front());
                if (e.data !== d || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL rdata%0d: got %h at cycle %0d expected %h at cycle %0d",
                             p, d, cyc, e.data, e.cyc);
                end
            end
        end else if (have && e.cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL rvalid%0d: got 0 expected read data %h (cycle %0d)", p, e.data, cyc);
            if (p == 0) void'(exp0.pop_front()); else void'(exp1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0, r0_rvalid, r0_rdata);
            mon(1, r1_rvalid, r1_rdata);
        end
    end

    // Drive one cycle of stimulus, check grants and the memory side, advance the model.
    // rae asserts reset just after the posedge that takes this cycle's transfer.
    task automatic step(input logic q0, input logic w0, input logic l0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic q1, input logic w1, input logic l1,
                        input logic [31:0] a1, input logic [31:0] d1, input bit rae);
        int          win;
        logic        we, lk;
        logic [31:0] a, d;
        exp_t        e;
        r0_req = q0; r0_we = w0; r0_lock = l0; r0_addr = a0; r0_wdata = d0;
        r1_req = q1; r1_we = w1; r1_lock = l1; r1_addr = a1; r1_wdata = d1;
        if (owner >= 0) win = ((owner == 0) ? q0 : q1) ? owner : -1;
        else if (q0 && q1) win = 1 - last;
        else if (q0) win = 0;
        else if (q1) win = 1;
        else win = -1;
        we = (win == 1) ? w1 : w0;
        lk = (win == 1) ? l1 : l0;
        a  = (win == 1) ? a1 : a0;
        d  = (win == 1) ? d1 : d0;
        #1;
        chk("gnt0", {31'd0, r0_gnt}, {31'd0, win == 0});
        chk("gnt1", {31'd0, r1_gnt}, {31'd0, win == 1});
        chk("m_we", {31'd0, m_we}, {31'd0, (win >= 0) && we});
        if (win >= 0) begin
            chk("m_addr", m_addr, a);
            if (we) begin
                shadow[a[9:2]] = d;
            end else begin
                e.cyc  = cyc + 1;
                e.data = shadow[a[9:2]];
                if (win == 0) exp0.push_back(e); else exp1.push_back(e);
            end
            last = win;
            if (owner < 0) begin
                if (lk && MB > 1) begin
                    owner = win;
                    burst = 1;
                end
            end else begin
                burst++;
                if (!lk || burst == MB) begin
                    owner = -1;
                    burst = 0;
                end
            end
        end
        if (rae) begin
            @(posedge clk);
            #1 reset = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        #1;
        chk("reset r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
        chk("reset r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
        chk("reset r0_rdata", r0_rdata, 32'd0);
        chk("reset r1_rdata", r1_rdata, 32'd0);
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'd0;
            shadow[i] = 32'd0;
        end
        model_reset();

        // 1: write then read back on port 0
        do_reset();
        step(1, 1, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        chk("t1 r0_rvalid", {31'd0, r0_rvalid}, 32'd1);
        chk("t1 r0_rdata", r0_rdata, 32'hDEADBEEF);
        chk("t1 r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 2: both request every cycle, no lock
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h8, 0, 1, 0, 0, 32'hC, 0, 0);

        // 3: port 1 locked reads against a persistent port 0 requester
        do_reset();
        step(0, 0, 0, 0, 0, 1, 0, 1, 32'h10, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 32'h4, 0, 1, 0, 1, 32'h10, 0, 0);

        // 4: port 0 burst with a two-cycle request gap
        do_reset();
        step(1, 1, 1, 32'h20, 32'h11, 1, 0, 0, 32'h20, 0, 0);
        step(0, 0, 1, 32'h20, 0, 1, 0, 0, 32'h20, 0, 0);
        step(0, 0, 1, 32'h20, 0, 1, 0, 0, 32'h20, 0, 0);
        step(1, 1, 1, 32'h24, 32'h22, 1, 0, 0, 32'h20, 0, 0);
        step(1, 0, 0, 32'h24, 0, 1, 0, 0, 32'h20, 0, 0);
        step(1, 0, 0, 32'h24, 0, 1, 0, 0, 32'h24, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 5: reset mid-burst with a read in flight
        do_reset();
        step(1, 1, 1, 32'h30, 32'h55, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h30, 0, 0, 0, 0, 0, 0, 1);
        model_reset();
        r0_req = 1; r0_we = 1; r1_req = 1; r1_we = 1;
        #1;
        chk("t5 gnt0 in reset", {31'd0, r0_gnt}, 32'd0);
        chk("t5 gnt1 in reset", {31'd0, r1_gnt}, 32'd0);
        chk("t5 m_we in reset", {31'd0, m_we}, 32'd0);
        chk("t5 r0_rvalid in reset", {31'd0, r0_rvalid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 0, 32'h30, 0, 1, 0, 0, 32'h34, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 6: cross-port read-after-write
        do_reset();
        step(0, 0, 0, 0, 0, 1, 1, 0, 32'h40, 32'h12345678, 0);
        step(1, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        chk("t6 r0_rdata", r0_rdata, 32'h12345678);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic on a small address window to provoke hazards
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0, 32'($urandom_range(0, 15)) << 2, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0, 32'($urandom_range(0, 15)) << 2, $urandom, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pending reads port 0", exp0.size(), 32'd0);
        chk("pending reads port 1", exp1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
